mem_wb_stage: RTL

- MEM/WB pipeline register and writeback mux for the 5-stage pipelined MIPS core.
- Captures memory-stage results, extends and aligns load data, and drives the register file's write port (busW, RW, RegWr) one cycle later.
- Also flags misaligned loads and keeps a retired-instruction counter for performance/debug.

---
 rtl/mem_wb_stage_if.sv | 38 +++
 rtl/mem_wb_stage.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage_if
// Purpose  : MEM-stage capture bus and WB register-file write port bundle.
// Revision : 1.0  initial release
// ============================================================================
interface mem_wb_stage_if #(
    parameter int COUNT_W = 32
);
    logic               stall;
    logic               flush;
    logic               mem_valid;
    logic [31:0]        mem_alu_result;
    logic [31:0]        mem_read_data;
    logic [4:0]         mem_rd;
    logic               mem_reg_wr;
    logic               mem_to_reg;
    logic [2:0]         mem_load_type;
    logic [31:0]        busW;
    logic [4:0]         RW;
    logic               RegWr;
    logic               wb_valid;
    logic               misalign;
    logic [COUNT_W-1:0] instret;

    modport master (
        output stall, flush, mem_valid, mem_alu_result, mem_read_data,
               mem_rd, mem_reg_wr, mem_to_reg, mem_load_type,
        input  busW, RW, RegWr, wb_valid, misalign, instret
    );

    modport slave (
        input  stall, flush, mem_valid, mem_alu_result, mem_read_data,
               mem_rd, mem_reg_wr, mem_to_reg, mem_load_type,
        output busW, RW, RegWr, wb_valid, misalign, instret
    );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MEM/WB pipeline register, load extension/alignment and writeback
//            port. Macro MEM_WB_LOAD_EXT_EN enables byte/half load extraction.
// Revision : 1.0  initial release
// ============================================================================
module mem_wb_stage #(
    parameter int COUNT_W        = 32,
    parameter int ADDR_LSB_CHECK = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_wb_stage_if.slave bus
);

    logic               r_valid;
    logic [31:0]        r_alu;
    logic [31:0]        r_data;
    logic [4:0]         r_rd;
    logic               r_reg_wr;
    logic               r_to_reg;
    logic [COUNT_W-1:0] r_instret;
`ifdef MEM_WB_LOAD_EXT_EN
    logic [2:0]         r_load_type;
`else
    logic               w_unused_load_type;
    assign w_unused_load_type = ^bus.mem_load_type;
`endif

    logic [31:0] w_busw;
    logic        w_is_word;
    logic        w_is_half;
    logic        w_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_alu       <= 32'd0;
            r_data      <= 32'd0;
            r_rd        <= 5'd0;
            r_reg_wr    <= 1'b0;
            r_to_reg    <= 1'b0;
            r_instret   <= '0;
`ifdef MEM_WB_LOAD_EXT_EN
            r_load_type <= 3'd0;
`endif
        end else begin
            if (bus.flush) begin
                r_valid <= 1'b0;
            end else if (!bus.stall) begin
                r_valid     <= bus.mem_valid;
                r_alu       <= bus.mem_alu_result;
                r_data      <= bus.mem_read_data;
                r_rd        <= bus.mem_rd;
                r_reg_wr    <= bus.mem_reg_wr;
                r_to_reg    <= bus.mem_to_reg;
`ifdef MEM_WB_LOAD_EXT_EN
                r_load_type <= bus.mem_load_type;
`endif
            end
            // The outgoing entry retires whenever it is released, flush or not.
            if (r_valid && !bus.stall) begin
                r_instret <= r_instret + COUNT_W'(1);
            end
        end
    end

`ifdef MEM_WB_LOAD_EXT_EN
    localparam logic [2:0] c_LT_LB  = 3'b001;
    localparam logic [2:0] c_LT_LBU = 3'b010;
    localparam logic [2:0] c_LT_LH  = 3'b011;
    localparam logic [2:0] c_LT_LHU = 3'b100;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'd0;
        case (r_alu[1:0])
            2'd0:    w_byte = r_data[31:24];
            2'd1:    w_byte = r_data[23:16];
            2'd2:    w_byte = r_data[15:8];
            default: w_byte = r_data[7:0];
        endcase
        w_half = r_alu[1] ? r_data[15:0] : r_data[31:16];
    end

    always_comb begin
        w_is_word = 1'b1;
        w_is_half = 1'b0;
        w_busw    = r_data;
        case (r_load_type)
            c_LT_LB: begin
                w_is_word = 1'b0;
                w_busw    = {{24{w_byte[7]}}, w_byte};
            end
            c_LT_LBU: begin
                w_is_word = 1'b0;
                w_busw    = {24'd0, w_byte};
            end
            c_LT_LH: begin
                w_is_word = 1'b0;
                w_is_half = 1'b1;
                w_busw    = {{16{w_half[15]}}, w_half};
            end
            c_LT_LHU: begin
                w_is_word = 1'b0;
                w_is_half = 1'b1;
                w_busw    = {16'd0, w_half};
            end
            default: begin
                w_is_word = 1'b1;
                w_busw    = r_data;
            end
        endcase
        if (!r_to_reg) begin
            w_busw = r_alu;
        end
    end
`else
    always_comb begin
        w_is_word = 1'b1;
        w_is_half = 1'b0;
        w_busw    = r_to_reg ? r_data : r_alu;
    end
`endif

    assign w_misalign = r_valid && r_to_reg && (ADDR_LSB_CHECK != 0) &&
                        ((w_is_word && (r_alu[1:0] != 2'b00)) ||
                         (w_is_half && r_alu[0]));

    assign bus.busW     = w_busw;
    assign bus.RW       = r_rd;
    assign bus.RegWr    = r_valid && r_reg_wr && (r_rd != 5'd0) && !w_misalign;
    assign bus.wb_valid = r_valid;
    assign bus.misalign = w_misalign;
    assign bus.instret  = r_instret;

endmodule
`default_nettype wire
